// File: rtl/cfg_scan_chain_if.sv
// Scan segment bus: shift/capture/update controls in, live config and status out.
// Latency: n/a (wiring only).
// Backpressure: none; every control is sampled every clock.
//
// Signals:
//   scan_en, scan_in, capture, update   controls driven by the scan controller
//   scan_out                            registered scan data towards the next segment
//   out                                 live configuration bits
//   shift_cnt, chain_full, update_err   load progress and error status
interface cfg_scan_chain_if #(
  parameter int SIZE   = 32,
  parameter int SCAN_W = 1
);
  localparam int DEPTH = SIZE / SCAN_W;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              scan_en;
  logic [SCAN_W-1:0] scan_in;
  logic [SCAN_W-1:0] scan_out;
  logic              capture;
  logic              update;
  logic [SIZE-1:0]   out;
  logic [CNT_W-1:0]  shift_cnt;
  logic              chain_full;
  logic              update_err;

  // Scan controller side.
  modport master (
    output scan_en, scan_in, capture, update,
    input  scan_out, out, shift_cnt, chain_full, update_err
  );

  // Scan segment side.
  modport slave (
    input  scan_en, scan_in, capture, update,
    output scan_out, out, shift_cnt, chain_full, update_err
  );
endinterface

// File: rtl/cfg_scan_chain.sv
// Config scan segment: SCAN_W-lane shift register plus shadow register driving the fabric.
// Latency: a word shifted in on shift k leaves on scan_out after shift k+DEPTH; update visible next cycle.
// Backpressure: none; capture > scan_en > update each cycle, losing requests are dropped silently.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (discards any partial load, out returns to RESET_VAL)
//   bus    cfg_scan_chain_if slave: scan_en/scan_in/capture/update in;
//          scan_out/out/shift_cnt/chain_full/update_err out
module cfg_scan_chain #(
  parameter int              SIZE      = 32,
  parameter int              SCAN_W    = 1,
  parameter logic [SIZE-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cfg_scan_chain_if.slave       bus
);
  localparam int DEPTH = SIZE / SCAN_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // The load state lives entirely in shift_cnt; this enum is a decoded view of it.
  typedef enum logic [1:0] {
    LS_IDLE    = 2'd0,
    LS_LOADING = 2'd1,
    LS_FULL    = 2'd2
  } load_state_t;

  logic [SIZE-1:0]   sreg_q;
  logic [SIZE-1:0]   shadow_q;
  logic [SCAN_W-1:0] scan_out_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  logic [SIZE-1:0]   sreg_shifted;
  load_state_t       load_state;

  // Guard against a width that would leave a partial word at the top of the chain.
  if ((SIZE % SCAN_W) != 0 || SIZE < SCAN_W) begin : g_bad_size
    $error("cfg_scan_chain: SIZE must be a non-zero multiple of SCAN_W");
  end

  // A one-word segment has no lower bits to carry along, so the concat collapses.
  if (DEPTH == 1) begin : g_one_word
    assign sreg_shifted = bus.scan_in;
  end else begin : g_multi_word
    assign sreg_shifted = {sreg_q[SIZE-SCAN_W-1:0], bus.scan_in};
  end

  always_comb begin
    load_state = LS_LOADING;
    if (cnt_q == '0) begin
      load_state = LS_IDLE;
    end else if (cnt_q == DEPTH_C) begin
      load_state = LS_FULL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q     <= '0;
      shadow_q   <= RESET_VAL;
      scan_out_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else if (bus.capture) begin
      // Readback: live config goes into the chain, load restarts, error is acknowledged.
      sreg_q <= shadow_q;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else if (bus.scan_en) begin
      scan_out_q <= sreg_q[SIZE-1 -: SCAN_W];
      sreg_q     <= sreg_shifted;
      // Keep shifting once full so data passes through to downstream segments.
      if (cnt_q != DEPTH_C) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (bus.update) begin
      if (load_state == LS_FULL) begin
        shadow_q <= sreg_q;
        cnt_q    <= '0;
      end else begin
        // Premature update: keep the old config and flag it until capture/reset.
        err_q <= 1'b1;
      end
    end
  end

  assign bus.scan_out   = scan_out_q;
  assign bus.out        = shadow_q;
  assign bus.shift_cnt  = cnt_q;
  assign bus.chain_full = (load_state == LS_FULL);
  assign bus.update_err = err_q;

endmodule

// File: tb/tb_cfg_scan_chain.sv
// Bench for cfg_scan_chain (SIZE=8, SCAN_W=2, RESET_VAL=8'hA5).
// Latency: n/a.
// Backpressure: n/a.
module tb_cfg_scan_chain;
  localparam int SIZE   = 8;
  localparam int SCAN_W = 2;
  localparam int DEPTH  = 4;
  localparam logic [7:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cfg_scan_chain_if #(.SIZE(SIZE), .SCAN_W(SCAN_W)) bus ();

  cfg_scan_chain #(.SIZE(SIZE), .SCAN_W(SCAN_W), .RESET_VAL(RV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the chain is a queue of words, index 0 newest, last oldest.
  logic [1:0] m_chain[$];
  logic [7:0] m_out;
  logic [1:0] m_so;
  int         m_cnt;
  bit         m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] chain_val();
    logic [7:0] v = '0;
    for (int i = 0; i < DEPTH; i++) v = v | (8'(m_chain[i]) << (i * SCAN_W));
    return v;
  endfunction

  task automatic model_reset();
    m_chain = {};
    for (int i = 0; i < DEPTH; i++) m_chain.push_back(2'b00);
    m_out = RV;
    m_so  = 2'b00;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic model_clock(input bit en, input logic [1:0] din, input bit cap, input bit upd);
    if (cap) begin
      for (int i = 0; i < DEPTH; i++) m_chain[i] = m_out[i*SCAN_W +: SCAN_W];
      m_cnt = 0;
      m_err = 1'b0;
    end else if (en) begin
      m_so = m_chain[DEPTH-1];
      void'(m_chain.pop_back());
      m_chain.push_front(din);
      m_cnt = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
    end else if (upd) begin
      if (m_cnt == DEPTH) begin
        m_out = chain_val();
        m_cnt = 0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"},        32'(bus.out),        32'(m_out));
    check({tag, ".scan_out"},   32'(bus.scan_out),   32'(m_so));
    check({tag, ".shift_cnt"},  32'(bus.shift_cnt),  32'(m_cnt));
    check({tag, ".chain_full"}, 32'(bus.chain_full), 32'(m_cnt == DEPTH));
    check({tag, ".update_err"}, 32'(bus.update_err), 32'(m_err));
  endtask

  // Called at a falling edge: drive, clock, then compare at the next falling edge.
  task automatic cyc(input bit en, input logic [1:0] din, input bit cap, input bit upd,
                     input string tag);
    bus.scan_en = en;
    bus.scan_in = din;
    bus.capture = cap;
    bus.update  = upd;
    @(posedge clk);
    model_clock(en, din, cap, upd);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, ".rst_out"}, 32'(bus.out), 32'(RV));
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [1:0] words[6];
  logic [1:0] pat[4];

  initial begin
    bus.scan_en = 1'b0;
    bus.scan_in = '0;
    bus.capture = 1'b0;
    bus.update  = 1'b0;
    model_reset();

    // 1: reset state, asserted away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("t1.out", 32'(bus.out), 32'hA5);
    check_all("t1");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 2: full load then update
    pat[0] = 2'b11; pat[1] = 2'b00; pat[2] = 2'b10; pat[3] = 2'b01;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, pat[k], 1'b0, 1'b0, "t2.shift");
      check("t2.cnt", 32'(bus.shift_cnt), 32'(k + 1));
      check("t2.out_hold", 32'(bus.out), 32'hA5);
    end
    check("t2.full", 32'(bus.chain_full), 32'd1);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, "t2.upd");
    check("t2.out_new", 32'(bus.out), 32'hC9);
    check("t2.cnt0", 32'(bus.shift_cnt), 32'd0);

    // 3: premature update, cleared by capture
    for (int k = 0; k < 3; k++) cyc(1'b1, 2'(k), 1'b0, 1'b0, "t3.shift");
    cyc(1'b0, 2'b00, 1'b0, 1'b1, "t3.upd");
    check("t3.err", 32'(bus.update_err), 32'd1);
    check("t3.cnt", 32'(bus.shift_cnt), 32'd3);
    check("t3.out", 32'(bus.out), 32'hC9);
    cyc(1'b0, 2'b00, 1'b1, 1'b0, "t3.cap");
    check("t3.err_clr", 32'(bus.update_err), 32'd0);

    // 4: readback of C9 through scan_out
    cyc(1'b0, 2'b00, 1'b1, 1'b0, "t4.cap");
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 2'b00, 1'b0, 1'b0, "t4.shift");
      check("t4.so", 32'(bus.scan_out), 32'(pat[k]));
    end
    check("t4.sreg", 32'(chain_val()), 32'd0);
    check("t4.out", 32'(bus.out), 32'hC9);

    // 5: pass-through beyond DEPTH
    for (int k = 0; k < 6; k++) words[k] = 2'($urandom_range(0, 3));
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, words[k], 1'b0, 1'b0, "t5.shift");
      if (k == 4) check("t5.w1", 32'(bus.scan_out), 32'(words[0]));
      if (k == 5) check("t5.w2", 32'(bus.scan_out), 32'(words[1]));
    end
    check("t5.cnt", 32'(bus.shift_cnt), 32'd4);

    // 6: simultaneous requests and mid-load reset
    cyc(1'b1, 2'b01, 1'b1, 1'b1, "t6.all");
    check("t6.cnt_cap", 32'(bus.shift_cnt), 32'd0);
    cyc(1'b1, 2'b10, 1'b0, 1'b1, "t6.en_upd");
    check("t6.no_err", 32'(bus.update_err), 32'd0);
    cyc(1'b1, 2'b11, 1'b0, 1'b0, "t6.shift2");
    async_reset("t6.rst");

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd.rst");
      end else begin
        cyc($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
